spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: bits per SPI word.
REQ-002 The block SHALL have parameter IDLE_FILL, default 8'h00: MISO word sent when no TX word is pending.
REQ-003 The block SHALL have port i_clk, input, 1, the single system clock; every flop is clocked on its rising edge.
REQ-004 The block SHALL have port i_RST, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port i_SCLK, input, 1, SPI serial clock from the master; asynchronous to i_clk.
REQ-006 The block SHALL have port i_SS_n, input, 1, active-low slave select; asynchronous.
REQ-007 The block SHALL have port i_MOSI, input, 1, master-out data; asynchronous.
REQ-008 The block SHALL have port o_MISO, output, 1, slave-out data.
REQ-009 The block SHALL have port o_MISO_En, output, 1, MISO drive enable (high while selected).
REQ-010 The block SHALL have port i_TX_Data, input, DATA_WIDTH, next word to transmit.
REQ-011 The block SHALL have port i_TX_Valid, input, 1, i_TX_Data is valid.
REQ-012 The block SHALL have port o_TX_Ready, output, 1, the pending-TX register is empty.
REQ-013 The block SHALL have port o_RX_Data, output, DATA_WIDTH, last received word; held until the next word completes.
REQ-014 The block SHALL have port o_RX_Valid, output, 1, one-cycle pulse when o_RX_Data updates.
REQ-015 The block SHALL have port o_TX_Underrun, output, 1, one-cycle pulse when IDLE_FILL is loaded for lack of a pending word.
REQ-016 The block SHALL have port o_Frame_Err, output, 1, one-cycle pulse when i_SS_n deasserts mid-word.

Function
REQ-017 The block SHALL operate in SPI mode 0 (CPOL=0, CPHA=0), MSB first; i_clk SHALL be at least 4x the SCLK frequency.
REQ-018 The block SHALL pass i_SCLK, i_SS_n and i_MOSI through 2-flop synchronizers; edges are detected on the synchronized signals.
REQ-019 The FSM SHALL have states IDLE and SHIFT: synchronized SS_n falling moves IDLE->SHIFT; synchronized SS_n rising moves any state->IDLE.
REQ-020 On IDLE->SHIFT the block SHALL load the TX shift register from the pending register, or from IDLE_FILL (pulsing o_TX_Underrun) if none is pending, and drive its MSB on o_MISO in that same cycle.
REQ-021 In SHIFT, each synchronized SCLK rising edge SHALL shift the synchronized MOSI into the RX shift register LSB and increment the bit counter.
REQ-022 In SHIFT, each synchronized SCLK falling edge SHALL shift the TX register left and present the next bit on o_MISO.
REQ-023 When a rising edge completes bit DATA_WIDTH-1, the counter SHALL wrap to 0, the completed word SHALL go to o_RX_Data, and o_RX_Valid SHALL pulse in the next i_clk cycle.
REQ-024 On the falling edge that follows a completed word, with SS_n still low, the block SHALL reload the TX register per REQ-020 (back-to-back words).
REQ-025 A TX handshake SHALL occur when i_TX_Valid and o_TX_Ready are both high on a clock edge; o_TX_Ready SHALL drop the next cycle and return high the cycle after the pending word is moved into the shift register.
REQ-026 If a load and a new handshake occur in the same cycle, the load SHALL take the old pending word and the new word SHALL become pending.
REQ-027 If SS_n rises with the bit counter nonzero, the block SHALL discard the partial word, leave o_RX_Valid low, pulse o_Frame_Err, and clear the counter; the pending TX word SHALL be retained.
REQ-028 o_MISO_En SHALL equal (state==SHIFT); o_MISO SHALL be 0 in IDLE.

Reset
REQ-029 While i_RST is high, the block SHALL hold: state IDLE, counter 0, shift registers 0, o_MISO 0, o_MISO_En 0, o_RX_Data 0, o_RX_Valid 0, o_TX_Underrun 0, o_Frame_Err 0, pending register empty, o_TX_Ready 1, synchronizers at idle levels (SCLK 0, SS_n 1, MOSI 0).
REQ-030 Reset asserted mid-word SHALL abort the word with no output pulses.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state enum, the DATA_WIDTH default and the IDLE_FILL default.
REQ-032 The bit counter SHALL be a sub-module spi_bit_counter (enable, clear, wrap flag at DATA_WIDTH-1).

Verification
REQ-033 Pre-load 8'hA5, master sends 8'h3C in one frame -> master receives 8'hA5, o_RX_Data=8'h3C, one o_RX_Valid pulse.
REQ-034 No pending word, SS_n falls -> o_TX_Underrun pulses once and master receives 8'h00.
REQ-035 Three back-to-back words 8'h01, 8'h02, 8'h03 with TX words 8'h11, 8'h22 refilled per o_TX_Ready -> RX pulses 01,02,03; MISO carries 11,22,00, with underrun on the third word.
REQ-036 SS_n rises after 5 bits -> o_Frame_Err pulses, no o_RX_Valid; the next full frame receives correctly.
REQ-037 i_RST pulsed after 4 bits -> all outputs at reset values; the next frame is correct.
REQ-038 Handshake in the same cycle as a frame-start load -> the old word is sent now and the new word is sent in the next word.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI slave slice: the FSM state encoding, the
// default word width, the default MISO fill word and a small helper that
// sizes the bit counter.
package spi_pkg;

  localparam int         SPI_DATA_WIDTH = 8;
  localparam logic [7:0] SPI_IDLE_FILL  = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  // Counter width able to hold 0 .. w-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter
// Counts SCLK rising edges within one SPI word.
// Ports:
//   i_clk  - system clock
//   i_RST  - asynchronous active-high reset
//   en     - advance the count by one (wraps to 0 after DATA_WIDTH-1)
//   clr    - synchronous clear, wins over en
//   count  - current bit index
//   wrap   - high while count sits on the last bit of a word
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int CNT_W      = cnt_width(DATA_WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_RST,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  assign wrap = (count == CNT_W'(DATA_WIDTH - 1));

  // Bit index register; an enable on the last bit rolls back to zero so the
  // next word starts cleanly without an explicit clear.
  always_ff @(posedge i_clk or posedge i_RST) begin
    if (i_RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// spi_slave
// SPI mode 0 (CPOL=0, CPHA=0), MSB-first slave running entirely in the i_clk
// domain. SCLK, SS_n and MOSI are synchronized and edge-detected; i_clk must
// run at least 4x SCLK.
// Ports:
//   i_clk, i_RST          - system clock, asynchronous active-high reset
//   i_SCLK, i_SS_n, i_MOSI - raw SPI inputs from the master
//   o_MISO, o_MISO_En     - slave data out and its drive enable
//   i_TX_Data/i_TX_Valid, o_TX_Ready - one-deep pending transmit word
//   o_RX_Data, o_RX_Valid - last received word and its update pulse
//   o_TX_Underrun         - pulse when IDLE_FILL had to be sent
//   o_Frame_Err           - pulse when SS_n rose in the middle of a word
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH = SPI_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = SPI_IDLE_FILL
) (
  input  logic                  i_clk,
  input  logic                  i_RST,
  input  logic                  i_SCLK,
  input  logic                  i_SS_n,
  input  logic                  i_MOSI,
  output logic                  o_MISO,
  output logic                  o_MISO_En,
  input  logic [DATA_WIDTH-1:0] i_TX_Data,
  input  logic                  i_TX_Valid,
  output logic                  o_TX_Ready,
  output logic [DATA_WIDTH-1:0] o_RX_Data,
  output logic                  o_RX_Valid,
  output logic                  o_TX_Underrun,
  output logic                  o_Frame_Err
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  logic sclk_meta, sclk_sync, sclk_prev;
  logic ss_meta, ss_sync, ss_prev;
  logic mosi_meta, mosi_sync;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  spi_state_t state_q, state_d;

  logic             load_tx, shift_tx, shift_rx;
  logic             cnt_en, cnt_clr, frame_err_d;
  logic [CNT_W-1:0] bit_count;
  logic             bit_wrap;

  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] pending_data;
  logic                  pending_valid;
  logic                  tx_hs;

  // Two-flop synchronizers plus one history flop for edge detection. Reset
  // values are the bus idle levels so no spurious edge appears on release.
  always_ff @(posedge i_clk or posedge i_RST) begin
    if (i_RST) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= i_SCLK;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      ss_meta   <= i_SS_n;
      ss_sync   <= ss_meta;
      ss_prev   <= ss_sync;
      mosi_meta <= i_MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign ss_rise   = ss_sync & ~ss_prev;
  assign ss_fall   = ~ss_sync & ss_prev;

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_RST) begin
    if (i_RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes. Deselect has priority over any SCLK edge
  // seen in the same cycle, so a master that drops SCLK and raises SS_n
  // together ends the frame without triggering a reload. A falling edge with
  // the counter at zero can only follow a completed word, so it reloads the
  // TX register instead of shifting.
  always_comb begin
    state_d     = state_q;
    load_tx     = 1'b0;
    shift_tx    = 1'b0;
    shift_rx    = 1'b0;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          load_tx = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d     = IDLE;
          cnt_clr     = 1'b1;
          frame_err_d = (bit_count != '0);
        end else begin
          if (sclk_rise) begin
            shift_rx = 1'b1;
            cnt_en   = 1'b1;
          end
          if (sclk_fall) begin
            if (bit_count == '0) begin
              load_tx = 1'b1;
            end else begin
              shift_tx = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  spi_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_bit_counter (
    .i_clk (i_clk),
    .i_RST (i_RST),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (bit_count),
    .wrap  (bit_wrap)
  );

  // Receive path: the word is published when the last bit arrives, and the
  // valid pulse lines up with the new o_RX_Data value.
  always_ff @(posedge i_clk or posedge i_RST) begin
    if (i_RST) begin
      rx_sr      <= '0;
      o_RX_Data  <= '0;
      o_RX_Valid <= 1'b0;
    end else begin
      o_RX_Valid <= 1'b0;
      if (shift_rx) begin
        rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_sync};
        if (bit_wrap) begin
          o_RX_Data  <= {rx_sr[DATA_WIDTH-2:0], mosi_sync};
          o_RX_Valid <= 1'b1;
        end
      end
    end
  end

  assign o_TX_Ready = ~pending_valid;
  assign tx_hs      = i_TX_Valid & ~pending_valid;

  // Transmit path. A load always sees the pending register as it was before
  // this edge, so a handshake landing on the same edge becomes the next word.
  always_ff @(posedge i_clk or posedge i_RST) begin
    if (i_RST) begin
      tx_sr         <= '0;
      pending_data  <= '0;
      pending_valid <= 1'b0;
      o_TX_Underrun <= 1'b0;
    end else begin
      o_TX_Underrun <= 1'b0;
      if (load_tx) begin
        if (pending_valid) begin
          tx_sr <= pending_data;
        end else begin
          tx_sr         <= IDLE_FILL;
          o_TX_Underrun <= 1'b1;
        end
      end else if (shift_tx) begin
        tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
      end
      if (tx_hs) begin
        pending_data  <= i_TX_Data;
        pending_valid <= 1'b1;
      end else if (load_tx) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Frame error pulse, registered so it is a clean single-cycle strobe.
  always_ff @(posedge i_clk or posedge i_RST) begin
    if (i_RST) begin
      o_Frame_Err <= 1'b0;
    end else begin
      o_Frame_Err <= frame_err_d;
    end
  end

  assign o_MISO_En = (state_q == SHIFT);
  assign o_MISO    = o_MISO_En & tx_sr[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave
// Self-checking bench for spi_slave. The bench plays the SPI master (SCLK
// half period of 4 i_clk cycles) and the TX producer, and keeps a word-level
// model: a pending-word queue consumed once per started word, a queue of
// words the DUT must report on o_RX_Data, and expected pulse counts.
module tb_spi_slave;

  localparam int         DW   = 8;
  localparam logic [7:0] FILL = 8'h00;

  logic       i_clk = 1'b0;
  logic       i_RST;
  logic       i_SCLK;
  logic       i_SS_n;
  logic       i_MOSI;
  logic       o_MISO;
  logic       o_MISO_En;
  logic [7:0] i_TX_Data;
  logic       i_TX_Valid;
  logic       o_TX_Ready;
  logic [7:0] o_RX_Data;
  logic       o_RX_Valid;
  logic       o_TX_Underrun;
  logic       o_Frame_Err;

  int vectors      = 0;
  int miscompares  = 0;
  int obs_underrun = 0;
  int exp_underrun = 0;
  int obs_ferr     = 0;
  int exp_ferr     = 0;
  int obs_rx       = 0;
  int rx_rd        = 0;

  logic [7:0] pend_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] got_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] model_rx_hold;
  bit         offer_en[4];
  logic [7:0] offer_data[4];
  bit         sync_offer;
  logic [7:0] sync_data;

  spi_slave #(
    .DATA_WIDTH (DW),
    .IDLE_FILL  (FILL)
  ) dut (
    .i_clk         (i_clk),
    .i_RST         (i_RST),
    .i_SCLK        (i_SCLK),
    .i_SS_n        (i_SS_n),
    .i_MOSI        (i_MOSI),
    .o_MISO        (o_MISO),
    .o_MISO_En     (o_MISO_En),
    .i_TX_Data     (i_TX_Data),
    .i_TX_Valid    (i_TX_Valid),
    .o_TX_Ready    (o_TX_Ready),
    .o_RX_Data     (o_RX_Data),
    .o_RX_Valid    (o_RX_Valid),
    .o_TX_Underrun (o_TX_Underrun),
    .o_Frame_Err   (o_Frame_Err)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare against the model: reset values while i_RST is high,
  // MISO quiet while not driven, and every RX pulse matched in order.
  always @(negedge i_clk) begin
    if (i_RST) begin
      checkOutput("reset_outputs",
                  32'({o_MISO, o_MISO_En, o_RX_Data, o_RX_Valid, o_TX_Underrun, o_Frame_Err, o_TX_Ready}),
                  32'({1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
    end else begin
      if (!o_MISO_En) checkOutput("miso_idle_low", 32'(o_MISO), 32'(0));
      if (o_RX_Valid) begin
        obs_rx++;
        if (rx_rd >= exp_rx.size()) begin
          checkOutput("rx_unexpected_pulse", 32'(o_RX_Valid), 32'(0));
        end else begin
          checkOutput("rx_data", 32'(o_RX_Data), 32'(exp_rx[rx_rd]));
          rx_rd++;
        end
      end
      if (o_TX_Underrun) obs_underrun++;
      if (o_Frame_Err)   obs_ferr++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One word leaves the pending slot for the shift register.
  function automatic logic [7:0] modelLoad();
    if (pend_q.size() > 0) return pend_q.pop_front();
    exp_underrun++;
    return FILL;
  endfunction

  task automatic offerTx(input logic [7:0] d);
    checkOutput("tx_ready_empty", 32'(o_TX_Ready), 32'(1));
    i_TX_Data  = d;
    i_TX_Valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_TX_Valid = 1'b0;
    pend_q.push_back(d);
    checkOutput("tx_ready_drop", 32'(o_TX_Ready), 32'(0));
    tick(1);
  endtask

  // Master drives one frame of nwords words from mosi_q; abort_bits > 0 cuts
  // the last word short after that many bits.
  task automatic applyStimulus(input int nwords, input int abort_bits);
    int         bits;
    logic [7:0] exp_tx;
    logic [7:0] rxw;
    got_q.delete();
    i_SS_n = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      if (w == 0 && sync_offer) begin
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("tx_ready_sync", 32'(o_TX_Ready), 32'(1));
        i_TX_Data  = sync_data;
        i_TX_Valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_TX_Valid = 1'b0;
        exp_tx = modelLoad();
        pend_q.push_back(sync_data);
      end else begin
        exp_tx = modelLoad();
      end
      bits = (w == nwords - 1 && abort_bits > 0) ? abort_bits : DW;
      if (bits == DW) exp_rx.push_back(mosi_q[w]);
      rxw = '0;
      for (int b = 0; b < bits; b++) begin
        i_MOSI = mosi_q[w][7-b];
        tick(4);
        checkOutput("miso_en_active", 32'(o_MISO_En), 32'(1));
        rxw    = {rxw[6:0], o_MISO};
        i_SCLK = 1'b1;
        if (offer_en[w] && b == 3 && pend_q.size() == 0) begin
          offerTx(offer_data[w]);
          tick(2);
        end else begin
          tick(4);
        end
        if (!(w == nwords - 1 && b == bits - 1)) i_SCLK = 1'b0;
      end
      if (bits == DW) begin
        checkOutput("master_rx_word", 32'(rxw), 32'(exp_tx));
        got_q.push_back(rxw);
        model_rx_hold = mosi_q[w];
      end
    end
    i_SS_n = 1'b1;
    i_SCLK = 1'b0;
    i_MOSI = 1'b0;
    if (abort_bits > 0) exp_ferr++;
    tick(6 + int'($urandom_range(0, 4)));
    checkOutput("miso_en_idle", 32'(o_MISO_En), 32'(0));
    checkOutput("underrun_count", 32'(obs_underrun), 32'(exp_underrun));
    checkOutput("frame_err_count", 32'(obs_ferr), 32'(exp_ferr));
    checkOutput("rx_backlog", 32'(rx_rd), 32'(exp_rx.size()));
    checkOutput("rx_data_hold", 32'(o_RX_Data), 32'(model_rx_hold));
    offer_en   = '{default: 1'b0};
    sync_offer = 1'b0;
  endtask

  // Starts a frame, sends four bits, queues a new pending word, then resets.
  task automatic resetMidWord();
    logic [7:0] exp_tx;
    offerTx(8'h99);
    i_SS_n = 1'b0;
    exp_tx = modelLoad();
    for (int b = 0; b < 4; b++) begin
      i_MOSI = b[0];
      tick(4);
      i_SCLK = 1'b1;
      if (b == 2) begin
        offerTx(8'h66);
        tick(2);
      end else begin
        tick(4);
      end
      if (b != 3) i_SCLK = 1'b0;
    end
    i_RST  = 1'b1;
    i_SS_n = 1'b1;
    i_SCLK = 1'b0;
    i_MOSI = 1'b0;
    pend_q.delete();
    model_rx_hold = 8'h00;
    tick(3);
    checkOutput("rst_tx_ready", 32'(o_TX_Ready), 32'(1));
    checkOutput("rst_rx_data", 32'(o_RX_Data), 32'(8'h00));
    i_RST = 1'b0;
    tick(4);
    checkOutput("rst_no_pulses", 32'(obs_underrun + obs_ferr), 32'(exp_underrun + exp_ferr));
  endtask

  initial begin
    int u0, f0, r0, nw, ab;
    i_RST         = 1'b1;
    i_SCLK        = 1'b0;
    i_SS_n        = 1'b1;
    i_MOSI        = 1'b0;
    i_TX_Valid    = 1'b0;
    i_TX_Data     = 8'h00;
    sync_offer    = 1'b0;
    sync_data     = 8'h00;
    model_rx_hold = 8'h00;
    offer_en      = '{default: 1'b0};
    offer_data    = '{default: 8'h00};
    tick(3);
    i_RST = 1'b0;
    tick(3);
    checkOutput("post_reset_ready", 32'(o_TX_Ready), 32'(1));
    checkOutput("post_reset_miso_en", 32'(o_MISO_En), 32'(0));

    // Preloaded A5 answered while 3C is received.
    offerTx(8'hA5);
    mosi_q = '{8'h3C};
    r0 = obs_rx;
    u0 = obs_underrun;
    applyStimulus(1, 0);
    checkOutput("t1_master_word", 32'(got_q[0]), 32'(8'hA5));
    checkOutput("t1_rx_data", 32'(o_RX_Data), 32'(8'h3C));
    checkOutput("t1_rx_pulses", 32'(obs_rx - r0), 32'(1));
    checkOutput("t1_underruns", 32'(obs_underrun - u0), 32'(0));

    // Nothing pending: fill word goes out with one underrun.
    mosi_q = '{8'h5E};
    u0 = obs_underrun;
    applyStimulus(1, 0);
    checkOutput("t2_master_word", 32'(got_q[0]), 32'(8'h00));
    checkOutput("t2_underruns", 32'(obs_underrun - u0), 32'(1));

    // Back-to-back words with a refill during the first word.
    offerTx(8'h11);
    mosi_q        = '{8'h01, 8'h02, 8'h03};
    offer_en[0]   = 1'b1;
    offer_data[0] = 8'h22;
    r0 = obs_rx;
    u0 = obs_underrun;
    applyStimulus(3, 0);
    checkOutput("t3_master_w0", 32'(got_q[0]), 32'(8'h11));
    checkOutput("t3_master_w1", 32'(got_q[1]), 32'(8'h22));
    checkOutput("t3_master_w2", 32'(got_q[2]), 32'(8'h00));
    checkOutput("t3_underruns", 32'(obs_underrun - u0), 32'(1));
    checkOutput("t3_rx_pulses", 32'(obs_rx - r0), 32'(3));
    checkOutput("t3_rx_data", 32'(o_RX_Data), 32'(8'h03));

    // Abort after 5 bits; a word queued during the abort survives it.
    mosi_q        = '{8'hC3};
    offer_en[0]   = 1'b1;
    offer_data[0] = 8'h5A;
    r0 = obs_rx;
    f0 = obs_ferr;
    applyStimulus(1, 5);
    checkOutput("t4_frame_err", 32'(obs_ferr - f0), 32'(1));
    checkOutput("t4_no_rx", 32'(obs_rx - r0), 32'(0));
    mosi_q = '{8'h96};
    applyStimulus(1, 0);
    checkOutput("t4_retained_word", 32'(got_q[0]), 32'(8'h5A));
    checkOutput("t4_rx_data", 32'(o_RX_Data), 32'(8'h96));

    // Reset mid-word clears the queued word; next frame still works.
    resetMidWord();
    mosi_q = '{8'h4B};
    applyStimulus(1, 0);
    checkOutput("t5_master_word", 32'(got_q[0]), 32'(8'h00));
    checkOutput("t5_rx_data", 32'(o_RX_Data), 32'(8'h4B));

    // Handshake on the frame-start load edge: fill now, new word next.
    sync_offer = 1'b1;
    sync_data  = 8'h77;
    mosi_q     = '{8'hE1, 8'h1E};
    applyStimulus(2, 0);
    checkOutput("t6_master_w0", 32'(got_q[0]), 32'(8'h00));
    checkOutput("t6_master_w1", 32'(got_q[1]), 32'(8'h77));

    // Randomized frames.
    repeat (40) begin
      nw = int'($urandom_range(1, 3));
      mosi_q.delete();
      for (int w = 0; w < nw; w++) begin
        mosi_q.push_back(8'($urandom));
        offer_en[w]   = ($urandom_range(0, 1) == 1);
        offer_data[w] = 8'($urandom);
      end
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
      if (pend_q.size() == 0 && $urandom_range(0, 1) == 1) offerTx(8'($urandom));
      applyStimulus(nw, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
